// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage: redirects on taken branches,
// fetches over a req/ready handshake and parks each instruction in a one-entry slot.
module fetch_pc_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter int               INC      = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      instr,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_pc,
    output logic             flush
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] r_req_addr;
    logic [WIDTH-1:0] w_req_addr_nxt;
    logic [WIDTH-1:0] r_instr_pc;
    logic [WIDTH-1:0] w_instr_pc_nxt;
    logic [15:0]      r_instr;
    logic [15:0]      w_instr_nxt;
    logic             r_instr_valid;
    logic             w_instr_valid_nxt;
    logic             r_imem_req;
    logic             w_imem_req_nxt;
    logic             r_flush;

    // Next-state and next-register values for the fetch sequencer
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_req_addr_nxt    = r_req_addr;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        // A non-stalled consumer takes the slot; reloads below override this.
        w_instr_valid_nxt = r_instr_valid & stall;
        w_imem_req_nxt    = 1'b0;

        case (r_state)
            ST_ISSUE: begin
                if (branch_taken) begin
                    // Squash the slot even when decode is stalled.
                    w_pc_nxt          = branch_target;
                    w_instr_valid_nxt = 1'b0;
                end else if (!r_instr_valid || !stall) begin
                    w_req_addr_nxt = r_pc;
                    w_state_nxt    = ST_REQ;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_REQ: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_state_nxt = imem_ready ? ST_ISSUE : ST_DRAIN;
                end else if (imem_ready) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_pc_nxt    = r_req_addr;
                    w_instr_valid_nxt = 1'b1;
                    w_pc_nxt          = r_req_addr + INC_W;
                    w_state_nxt       = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The stale request must complete before a new one may start.
                if (branch_taken) begin
                    w_pc_nxt = branch_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (imem_ready) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_ISSUE;
            end
        endcase

        w_imem_req_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_DRAIN);
    end

    // State, PC, request and output-slot registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_ISSUE;
            r_pc          <= RESET_PC;
            r_req_addr    <= {WIDTH{1'b0}};
            r_imem_req    <= 1'b0;
            r_instr       <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_instr_pc    <= {WIDTH{1'b0}};
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_imem_req    <= w_imem_req_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_flush       <= branch_taken;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_req_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign instr_pc    = r_instr_pc;
    assign flush       = r_flush;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: cycle vector table, scoreboard of
// accepted instructions, and hand sequences for stall, redirect and reset cases.
module tb_fetch_pc_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] instr_pc;
    logic        flush;

    logic        b2_zero = 1'b0;
    logic        b2_one  = 1'b1;
    logic [15:0] b2_tgt  = 16'h0000;
    logic        b2_req;
    logic [15:0] b2_addr;
    logic [15:0] b2_rdata = 16'h0000;
    logic [15:0] b2_instr;
    logic        b2_valid;
    logic [15:0] b2_pc;
    logic        b2_flush;

    int          total = 0;
    int          bad   = 0;
    int          waits = 0;
    int          cnt   = 0;
    int          n;
    int          nreq;
    logic        mon_en = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] mon_e;
    logic [15:0] sb_q[$];

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vt[8];

    fetch_pc_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_pc     (instr_pc),
        .flush        (flush)
    );

    fetch_pc_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clock        (clock),
        .reset_n      (reset_n),
        .branch_taken (b2_zero),
        .branch_target(b2_tgt),
        .stall        (b2_zero),
        .imem_req     (b2_req),
        .imem_addr    (b2_addr),
        .imem_ready   (b2_one),
        .imem_rdata   (b2_rdata),
        .instr        (b2_instr),
        .instr_valid  (b2_valid),
        .instr_pc     (b2_pc),
        .flush        (b2_flush)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: wait-stated ready, data = addr ^ A5A5, request hold check
    initial forever begin
        @(negedge clock);
        if (reset_n && prev_req && !prev_ready)
            chk("addr_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, prev_addr});
        if (imem_req) begin
            if (cnt >= waits) begin
                imem_ready = 1'b1;
                cnt = 0;
            end else begin
                imem_ready = 1'b0;
                cnt++;
            end
        end else begin
            imem_ready = 1'b0;
            cnt = 0;
        end
        imem_rdata = imem_addr ^ 16'hA5A5;
        b2_rdata   = b2_addr ^ 16'hA5A5;
        prev_req   = reset_n && imem_req;
        prev_addr  = imem_addr;
        prev_ready = imem_ready;
    end

    // Scoreboard: every instruction taken by decode must match the queue head
    initial forever begin
        @(negedge clock);
        #2;
        if (mon_en && reset_n && instr_valid && !stall) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got pc %h want none", instr_pc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_pc", instr_pc, mon_e);
                chk("sb_instr", instr, mon_e ^ 16'hA5A5);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hA5A5};
        vt[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'hA5A5};
        vt[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 16'h0001, 16'hA5A4};
        vt[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0001, 16'hA5A4};
        vt[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0002, 16'hA5A7};
        vt[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 16'h0002, 16'hA5A7};
        vt[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 16'h0003, 16'hA5A6};

        reset_n = 1'b1; branch_taken = 1'b0; branch_target = 16'h0000; stall = 1'b0;
        #1 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_pc", instr_pc, 16'h0000);
        chk("rst_flush", flush, 1'b0);
        for (int i = 0; i < 4; i++) sb_q.push_back(16'(i));
        mon_en = 1'b1;
        #1 reset_n = 1'b1;

        // Zero-wait streaming from reset
        for (int i = 0; i < 8; i++) begin
            stall = vt[i].stall; branch_taken = vt[i].br; branch_target = vt[i].tgt;
            @(negedge clock);
            chk("vec_req", imem_req, vt[i].e_req);
            chk("vec_addr", imem_addr, vt[i].e_addr);
            chk("vec_valid", instr_valid, vt[i].e_valid);
            chk("vec_pc", instr_pc, vt[i].e_pc);
            chk("vec_instr", instr, vt[i].e_instr);
            chk("vec_flush", flush, 1'b0);
            if (i == 1) begin
                chk("wrap_valid0", b2_valid, 1'b1);
                chk("wrap_pc0", b2_pc, 16'hFFFF);
                chk("wrap_instr0", b2_instr, 16'h5A5A);
            end
            if (i == 3) begin
                chk("wrap_valid1", b2_valid, 1'b1);
                chk("wrap_pc1", b2_pc, 16'h0000);
                chk("wrap_instr1", b2_instr, 16'hA5A5);
            end
            #1;
        end

        // Two wait states, then decode stalls on pc 5
        sb_q.push_back(16'h0004);
        sb_q.push_back(16'h0005);
        waits = 2;
        n = 0;
        while (!(imem_req && imem_addr == 16'h0005) && n < 60) begin @(negedge clock); n++; end
        chk("tmo_req5", n < 60, 1'b1);
        #1 stall = 1'b1;
        n = 0; nreq = 0;
        while (!(instr_valid && instr_pc == 16'h0005) && n < 60) begin
            if (imem_req) nreq++;
            @(negedge clock); n++;
        end
        chk("tmo_valid5", n < 60, 1'b1);
        chk("ws_req_cycles", nreq, 3);
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_pc", instr_pc, 16'h0005);
            chk("stall_instr", instr, 16'hA5A0);
            chk("stall_req", imem_req, 1'b0);
            @(negedge clock);
        end
        #1 stall = 1'b0;
        sb_q.push_back(16'h0006);
        @(negedge clock);
        chk("post_stall_req", imem_req, 1'b1);
        chk("post_stall_addr", imem_addr, 16'h0006);
        chk("post_stall_valid", instr_valid, 1'b0);

        // Redirect during a wait-stated request at addr 7
        n = 0;
        while (!(imem_req && imem_addr == 16'h0007) && n < 60) begin @(negedge clock); n++; end
        chk("tmo_req7", n < 60, 1'b1);
        #1 branch_taken = 1'b1; branch_target = 16'h0040;
        sb_q.push_back(16'h0040);
        @(negedge clock);
        chk("drain_flush", flush, 1'b1);
        chk("drain_req", imem_req, 1'b1);
        chk("drain_addr", imem_addr, 16'h0007);
        chk("drain_valid", instr_valid, 1'b0);
        #1 branch_taken = 1'b0;
        @(negedge clock);
        chk("drain_flush_off", flush, 1'b0);
        chk("drain_hold_req", imem_req, 1'b1);
        chk("drain_hold_addr", imem_addr, 16'h0007);
        #1 waits = 0;
        @(negedge clock);
        chk("drain_done_req", imem_req, 1'b0);
        chk("drain_done_valid", instr_valid, 1'b0);
        @(negedge clock);
        chk("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, 16'h0040);
        @(negedge clock);
        chk("redir_valid", instr_valid, 1'b1);
        chk("redir_pc", instr_pc, 16'h0040);

        // Redirect from ISSUE to 9, then redirect on the same edge as ready at 9
        #1 branch_taken = 1'b1; branch_target = 16'h0009;
        sb_q.push_back(16'h0100);
        @(negedge clock);
        chk("sq_flush", flush, 1'b1);
        chk("sq_valid", instr_valid, 1'b0);
        chk("sq_req", imem_req, 1'b0);
        #1 branch_taken = 1'b0;
        @(negedge clock);
        chk("req9", imem_req, 1'b1);
        chk("addr9", imem_addr, 16'h0009);
        #1 branch_taken = 1'b1; branch_target = 16'h0100;
        @(negedge clock);
        chk("race_valid", instr_valid, 1'b0);
        chk("race_req", imem_req, 1'b0);
        chk("race_flush", flush, 1'b1);
        #1 branch_taken = 1'b0;
        @(negedge clock);
        chk("req100", imem_req, 1'b1);
        chk("addr100", imem_addr, 16'h0100);
        chk("flush_once", flush, 1'b0);
        @(negedge clock);
        chk("valid100", instr_valid, 1'b1);
        chk("pc100", instr_pc, 16'h0100);
        chk("instr100", instr, 16'hA4A5);
        @(negedge clock);

        // Asynchronous reset while a request is outstanding
        #1 mon_en = 1'b0; waits = 3;
        chk("sb_empty", sb_q.size(), 0);
        chk("pre_rst_req", imem_req, 1'b1);
        reset_n = 1'b0;
        #2;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_addr", imem_addr, 16'h0000);
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_pc", instr_pc, 16'h0000);
        chk("arst_instr", instr, 16'h0000);
        chk("arst_flush", flush, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #1 reset_n = 1'b1; waits = 0;
        @(negedge clock);
        chk("restart_req", imem_req, 1'b1);
        chk("restart_addr", imem_addr, 16'h0000);
        @(negedge clock);
        chk("restart_valid", instr_valid, 1'b1);
        chk("restart_pc", instr_pc, 16'h0000);
        chk("restart_instr", instr, 16'hA5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter and instruction-fetch stage of the 16-bit processor. It sits directly downstream of the branch decision unit and consumes its taken/not-taken output plus the branch target. It redirects the PC on a taken branch and fetches instructions through a request/ready handshake to instruction memory. Fetched instructions go into a one-entry output slot that decode may stall.

Parameters:
WIDTH, 16, PC and instruction-address width
RESET_PC, 16'h0000, PC value loaded on reset
INC, 1, PC increment per instruction (word-addressed memory)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
branch_taken  in  1  taken decision from the branch unit, sampled on rising edge
branch_target  in  WIDTH  redirect address, valid when branch_taken=1
stall  in  1  decode cannot accept this cycle
imem_req  out  1  memory request, held until imem_ready
imem_addr  out  WIDTH  request address, stable while imem_req=1
imem_ready  in  1  memory completes the request this edge
imem_rdata  in  16  instruction word, valid when imem_ready=1
instr  out  16  output-slot instruction
instr_valid  out  1  output slot holds a valid instruction
instr_pc  out  WIDTH  address of instr
flush  out  1  one-cycle pulse the cycle after a redirect

Behaviour:
- Reset (reset_n=0, asynchronous): pc=RESET_PC, req_addr=0, state=ISSUE, imem_req=0, imem_addr=0, instr=0, instr_valid=0, instr_pc=0, flush=0.
- Handshake: a transaction completes on a rising edge with imem_req=1 and imem_ready=1. imem_req and imem_addr may not change until completion. imem_ready is ignored when imem_req=0.
- Consumer accept: on an edge with instr_valid=1 and stall=0, instr_valid is cleared unless it is reloaded on the same edge.
- imem_req=1 exactly in REQ and DRAIN. imem_addr=req_addr, held in a register.
- flush is registered: it is 1 for exactly one cycle after any edge where branch_taken=1, otherwise 0.
- branch_taken has priority over stall and over an arriving fetch.
- States:
  - ISSUE: no request.
    - Edge with branch_taken=1: pc<=branch_target, instr_valid<=0 (squash even if stalled), stay ISSUE.
    - Otherwise, if instr_valid=0 or stall=0: req_addr<=pc, go REQ.
    - Otherwise stay ISSUE and hold the slot.
  - REQ: entered only with the slot free or being accepted, so instr_valid=0 throughout.
    - branch_taken=1 and imem_ready=1: discard imem_rdata, pc<=branch_target, go ISSUE.
    - branch_taken=1 and imem_ready=0: pc<=branch_target, go DRAIN.
    - branch_taken=0 and imem_ready=1: instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1, pc<=req_addr+INC, go ISSUE.
    - Otherwise stay REQ.
  - DRAIN: the stale request stays asserted at the old req_addr until imem_ready.
    - imem_ready=1: discard data, go ISSUE.
    - branch_taken=1 in DRAIN: pc<=branch_target (latest target wins), flush pulses again, DRAIN continues.
- Latency: zero-wait memory gives the first instr_valid 2 edges after reset release. Peak throughput is one instruction per 2 cycles.
- Arithmetic: pc increments modulo 2^WIDTH, so 16'hFFFF+1 wraps to 16'h0000.
- Reset asserted mid-transaction drops the request immediately (imem_req=0) with no drain. Memory must tolerate an abandoned request.

Test Plan:
- Reset release, imem_ready=1 constant, stall=0, memory returns addr^16'hA5A5 -> instr_valid pulses every other cycle, instr_pc=0,1,2,3, instr=16'hA5A5,16'hA5A4,..., imem_addr stable while imem_req=1.
- Two wait states per fetch (imem_ready high on the 3rd REQ cycle) -> imem_req held 3 cycles at the same addr; instr_pc sequence is unchanged.
- instr_pc=5 valid, then stall=1 for 4 cycles -> instr/instr_valid hold, imem_req=0; after stall drops, the next request is addr 6.
- branch_taken=1, target=16'h0040, during a wait-stated REQ at addr 7 -> flush pulses, DRAIN holds addr 7 until ready, data is discarded, next request is addr 16'h0040.
- branch_taken=1 (target 16'h0100) on the same edge as imem_ready at addr 9 -> no instr_valid for addr 9, next instr_pc=16'h0100.
- RESET_PC=16'hFFFF -> instr_pc 16'hFFFF then 16'h0000. Separately, reset_n=0 mid-REQ -> imem_req and instr_valid drop asynchronously, and fetch restarts at RESET_PC.
